reduce_sched: RTL
=================

# reduce_sched

Multi-cycle reduction scheduler that shares a single `and16` reduction tree between two requesters. It computes a 64-bit AND-reduce or OR-reduce by feeding four 16-bit slices through the `and16` instance on consecutive cycles. OR-reduce uses De Morgan: the slices are inverted going in and the accumulated result is inverted coming out. The block sits beside the ALU/flag logic, which uses it for wide zero/all-ones detection, and arbitrates round-robin between its two clients.

## Interface
- Parameters: none. The operand is fixed at 64 bits, processed as 4 slices of 16 bits.
- `clk` in 1: the only clock.
- `rst` in 1: reset, synchronous and active-high.
- `req0_valid` in 1: requester 0 has an operation pending.
- `req0_op` in 1: requester 0 operation select; 0 = AND-reduce, 1 = OR-reduce.
- `req0_data` in 64: requester 0 operand.
- `req0_ack` out 1: combinational; high in the cycle requester 0 is accepted.
- `req1_valid`, `req1_op`, `req1_data`, `req1_ack`: same as requester 0, for requester 1.
- `busy` out 1: registered; high while a reduction is in flight.
- `done` out 1: registered; one-cycle pulse when the result is valid.
- `done_id` out 1: registered; index of the requester that owns `result`.
- `result` out 1: registered; the reduction result, valid while `done` is high.

## Operation
- States:
  - IDLE: waiting for a request.
  - BUSY: stepping through the slices; a 2-bit slice counter `cnt` runs 0..3.
  - DONE: presenting the result.
- Arbitration in IDLE:
  - If exactly one `valid` is high, that requester is granted.
  - If both are high, grant the requester that is not `last_grant`.
  - `reqN_ack` = (state == IDLE) & grantN & !rst.
  - At most one `ack` is high in any cycle.
- Acceptance edge:
  - latch `data`, `op` and id;
  - `last_grant` <= id;
  - `acc` <= 1;
  - `cnt` <= 0;
  - move to BUSY.
- BUSY, each cycle:
  - slice = `data[16*cnt+15 : 16*cnt]`, inverted when `op` = 1;
  - `acc` <= `acc` & `and16`(slice);
  - `cnt` increments;
  - after `cnt` == 3, move to DONE.
- DONE, single cycle:
  - `done` = 1;
  - `result` = `op` ? ~`acc` : `acc`;
  - `done_id` = latched id;
  - then return to IDLE.
- No early termination: a zero `acc` does not shorten latency, and all 4 slices are always processed.
- Requester rules:
  - hold `valid`, `op` and `data` stable until `ack`;
  - drop `valid` or present a new operation in the cycle after `ack`;
  - `data` is not sampled after the acceptance edge.
- Requests are not accepted in BUSY or DONE; `ack` stays 0 there.
- Exactly one `and16` instance; no second reduction tree is permitted.

## Timing
- Reset values:
  - state IDLE, `busy` 0, `done` 0, `done_id` 0, `result` 0;
  - `acc` 1, `cnt` 0;
  - `last_grant` 1, so requester 0 wins the first contention;
  - both acks 0 while `rst` is high.
- Latency, with acceptance in cycle 0:
  - `busy` is high in cycles 1–4;
  - `done`, `result` and `done_id` are valid in cycle 5;
  - the earliest next `ack` is cycle 6.
- Back-to-back throughput is one operation per 6 cycles.
- `done` is a pulse with no backpressure: the consumer must sample it in the DONE cycle.
- `result` and `done_id` hold their values until the next DONE.
- Reset mid-operation (`rst` high in BUSY or DONE):
  - the next state is IDLE with all registers at reset values;
  - no `done` pulse is produced for the aborted operation;
  - a requester still holding `valid` is re-arbitrated in the first cycle with `rst` low.
- Simultaneous requests with `last_grant` = 0 grant requester 1, and vice versa.
- A requester that drops `valid` before `ack` is simply not granted; no state change results.

## Test plan
- Reset: hold `rst` for 2 cycles with both valids high.
  - Expect acks 0, `busy`/`done`/`result`/`done_id` = 0.
  - In the first cycle after release, `req0_ack` = 1.
- req0 AND-reduce of 64'hFFFF_FFFF_FFFF_FFFF, accepted in cycle 0.
  - Expect `busy` high in cycles 1–4.
  - Expect `done` = 1, `result` = 1, `done_id` = 0 in cycle 5 only.
- req0 AND-reduce of 64'hFFFF_FFFF_FFFF_FFFE.
  - Expect `result` = 0 in cycle 5, with no early `done`.
- req1 OR-reduce of 64'h0000_0000_0000_0000, then of 64'h0001_0000_0000_0000.
  - Expect `result` = 0, then `result` = 1.
  - Both have `done_id` = 1; the second proves slice 3 is processed.
- Both valids held high continuously.
  - Acks alternate 0, 1, 0, 1 at cycles 0, 6, 12, 18.
  - `done_id` alternates to match, at cycles 5, 11, 17, 23.
- Abort: assert `rst` for 1 cycle during BUSY (`cnt` = 2) of a req0 op while `req1_valid` is held high.
  - Expect no `done` pulse and `busy` = 0 after the reset cycle.
  - Expect `req1_ack` = 1 in the first cycle after `rst` falls.

Source files
------------

// File: rtl/reduce_sched.sv
// reduce_sched: shares one 16-bit AND reduction tree between two requesters
// to compute 64-bit AND-reduce / OR-reduce over four consecutive cycles.
// OR-reduce is done by inverting each slice going in and the result coming out.

// 16-bit AND reduction tree; the only one in this block.
module and16 (
    input  logic [15:0] a,
    output logic        y
);
    assign y = &a;
endmodule

module reduce_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req0_op,
    input  logic [63:0] req0_data,
    output logic        req0_ack,
    input  logic        req1_valid,
    input  logic        req1_op,
    input  logic [63:0] req1_data,
    output logic        req1_ack,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic        result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    logic [1:0]  cnt_reg;
    logic        acc_reg;
    logic        op_reg;
    logic        id_reg;
    logic [63:0] data_reg;
    logic        last_grant_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        done_id_reg;
    logic        result_reg;

    logic        grant0;
    logic        grant1;
    logic [15:0] slice_arr [4];
    logic [15:0] slice_in;
    logic        slice_and;
    logic        acc_next;

    // Round-robin: a lone requester wins; on contention the one not granted last time wins.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant_reg);
        grant1 = req1_valid & (~req0_valid | ~last_grant_reg);
    end

    assign req0_ack = (state_reg == IDLE) & grant0 & ~rst;
    assign req1_ack = (state_reg == IDLE) & grant1 & ~rst;

    // Split the latched operand into its four 16-bit slices.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slice
            assign slice_arr[gi] = data_reg[16*gi +: 16];
        end
    endgenerate

    // Select the current slice; invert it for OR-reduce (De Morgan).
    always_comb begin
        slice_in = slice_arr[cnt_reg] ^ {16{op_reg}};
        acc_next = acc_reg & slice_and;
    end

    and16 u_and16 (
        .a (slice_in),
        .y (slice_and)
    );

    // Scheduler FSM: accept, step through four slices, present the result for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 2'd0;
            acc_reg        <= 1'b1;
            op_reg         <= 1'b0;
            id_reg         <= 1'b0;
            data_reg       <= 64'd0;
            last_grant_reg <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            done_id_reg    <= 1'b0;
            result_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (grant0 | grant1) begin
                        data_reg       <= grant1 ? req1_data : req0_data;
                        op_reg         <= grant1 ? req1_op : req0_op;
                        id_reg         <= grant1;
                        last_grant_reg <= grant1;
                        acc_reg        <= 1'b1;
                        cnt_reg        <= 2'd0;
                        busy_reg       <= 1'b1;
                        state_reg      <= BUSY;
                    end
                end
                BUSY: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        result_reg  <= op_reg ? ~acc_next : acc_next;
                        done_id_reg <= id_reg;
                        state_reg   <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign done_id = done_id_reg;
    assign result  = result_reg;

endmodule
